// File: rtl/control_unit_param.sv
// Microcoded control FSM for the 8-bit processor family: fetch/decode/sequence
// with a hardware return stack, memory wait states, flag jumps and a sticky fault.
module control_unit_param #(
  parameter int FIELD_W     = 8,
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = $clog2(STACK_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3*FIELD_W-1:0]   command_word,
  input  logic                   ReadyRegFlag,
  input  logic [FIELD_W-1:0]     PC_current_value,
  input  logic                   alu_zero,
  input  logic                   mem_ready,
  output logic [FIELD_W-1:0]     PC_load,
  output logic                   PC_en,
  output logic                   PC_inc,
  output logic                   MAR_load,
  output logic                   IR_load,
  output logic [FIELD_W-1:0]     write_data,
  output logic [FIELD_W-1:0]     ALU_sel,
  output logic [FIELD_W-1:0]     ADR_1,
  output logic [FIELD_W-1:0]     ADR_2,
  output logic [FIELD_W-1:0]     ADR_3,
  output logic                   regWriteEnable,
  output logic                   regReadEnable,
  output logic [1:0]             Path_Type,
  output logic                   rd_en,
  output logic                   wr_en,
  output logic [4:0]             current_state_out,
  output logic                   fault,
  output logic [SP_W:0]          stack_count
);

  localparam logic [FIELD_W-1:0] OP_NOP     = FIELD_W'(8'h00);
  localparam logic [FIELD_W-1:0] OP_STR_IMM = FIELD_W'(8'h01);
  localparam logic [FIELD_W-1:0] OP_LOA_DIR = FIELD_W'(8'h02);
  localparam logic [FIELD_W-1:0] OP_STR_DIR = FIELD_W'(8'h03);
  localparam logic [FIELD_W-1:0] OP_MOV     = FIELD_W'(8'h04);
  localparam logic [FIELD_W-1:0] OP_ALU_LO  = FIELD_W'(8'h10);
  localparam logic [FIELD_W-1:0] OP_ALU_HI  = FIELD_W'(8'h2F);
  localparam logic [FIELD_W-1:0] OP_JMP     = FIELD_W'(8'h30);
  localparam logic [FIELD_W-1:0] OP_JZ      = FIELD_W'(8'h31);
  localparam logic [FIELD_W-1:0] OP_JNZ     = FIELD_W'(8'h32);
  localparam logic [FIELD_W-1:0] OP_CALL    = FIELD_W'(8'h33);
  localparam logic [FIELD_W-1:0] OP_RET     = FIELD_W'(8'h34);
  localparam logic [SP_W:0]      CNT_FULL   = (SP_W+1)'(STACK_DEPTH);

  typedef enum logic [4:0] {
    FETCH_0 = 5'd0,  FETCH_1 = 5'd1,  FETCH_2 = 5'd2,  DECODE = 5'd3,
    EXEC    = 5'd4,  MEM_RD  = 5'd5,  MEM_WB  = 5'd6,  MEM_WR = 5'd7,
    ALU_0   = 5'd8,  ALU_1   = 5'd9,  ALU_2   = 5'd10, JUMP   = 5'd11,
    FAULT   = 5'd31
  } state_t;

  state_t                 state_r, state_s;
  logic [3*FIELD_W-1:0]   ir_r, instr_s;
  logic [FIELD_W-1:0]     op_s, fa_s, fb_s, jump_tgt_s;
  logic                   is_alu_s, is_mov_s, push_s, pop_s;
  logic [FIELD_W-1:0]     stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]        sp_r, sp_dec_s;
  logic [SP_W:0]          count_r;

  logic [FIELD_W-1:0] pc_load_s, write_data_s, alu_sel_s, adr_1_s, adr_2_s, adr_3_s;
  logic               pc_en_s, pc_inc_s, mar_load_s, ir_load_s, reg_we_s, reg_re_s;
  logic               rd_en_s, wr_en_s, fault_s;
  logic [1:0]         path_type_s;

  // The IR is live during DECODE; later execute states use the latched copy.
  always_comb begin
    if (state_r == DECODE) begin
      instr_s = command_word;
    end else begin
      instr_s = ir_r;
    end
  end

  assign op_s     = instr_s[3*FIELD_W-1:2*FIELD_W];
  assign fa_s     = instr_s[2*FIELD_W-1:FIELD_W];
  assign fb_s     = instr_s[FIELD_W-1:0];
  assign is_alu_s = (op_s >= OP_ALU_LO) && (op_s <= OP_ALU_HI);
  assign is_mov_s = (op_s == OP_MOV);
  assign sp_dec_s = sp_r - SP_W'(1);

  // Next-state selection, stack push/pop requests and jump target.
  always_comb begin
    state_s    = state_r;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    jump_tgt_s = fa_s;
    case (state_r)
      FETCH_0: state_s = FETCH_1;
      FETCH_1: state_s = FETCH_2;
      FETCH_2: begin
        if (ReadyRegFlag) state_s = DECODE;
        else              state_s = FETCH_0;
      end
      DECODE: begin
        if      (op_s == OP_NOP)          state_s = FETCH_0;
        else if (op_s == OP_STR_IMM)      state_s = EXEC;
        else if (op_s == OP_LOA_DIR)      state_s = MEM_RD;
        else if (op_s == OP_STR_DIR)      state_s = MEM_WR;
        else if (is_mov_s || is_alu_s)    state_s = ALU_0;
        else if (op_s == OP_JMP)          state_s = JUMP;
        else if (op_s == OP_JZ)           state_s = alu_zero ? JUMP : FETCH_0;
        else if (op_s == OP_JNZ)          state_s = alu_zero ? FETCH_0 : JUMP;
        else if (op_s == OP_CALL) begin
          if (count_r == CNT_FULL) begin
            state_s = FAULT;
          end else begin
            push_s  = 1'b1;
            state_s = JUMP;
          end
        end else if (op_s == OP_RET) begin
          if (count_r == '0) begin
            state_s = FAULT;
          end else begin
            pop_s      = 1'b1;
            jump_tgt_s = stack_mem[sp_dec_s];
            state_s    = JUMP;
          end
        end else begin
          state_s = FAULT;
        end
      end
      EXEC:    state_s = FETCH_0;
      MEM_RD: begin
        if (mem_ready) state_s = MEM_WB;
        else           state_s = MEM_RD;
      end
      MEM_WB:  state_s = FETCH_0;
      MEM_WR: begin
        if (mem_ready) state_s = FETCH_0;
        else           state_s = MEM_WR;
      end
      ALU_0:   state_s = is_mov_s ? ALU_2 : ALU_1;
      ALU_1:   state_s = ALU_2;
      ALU_2:   state_s = FETCH_0;
      JUMP:    state_s = FETCH_0;
      FAULT:   state_s = FAULT;
      default: state_s = FAULT;
    endcase
  end

  // Output values for the state being entered; registered below so they line up with it.
  always_comb begin
    pc_load_s    = '0;
    write_data_s = '0;
    alu_sel_s    = '0;
    adr_1_s      = '0;
    adr_2_s      = '0;
    adr_3_s      = '0;
    pc_en_s      = 1'b0;
    pc_inc_s     = 1'b0;
    mar_load_s   = 1'b0;
    ir_load_s    = 1'b0;
    reg_we_s     = 1'b0;
    reg_re_s     = 1'b0;
    rd_en_s      = 1'b0;
    wr_en_s      = 1'b0;
    fault_s      = 1'b0;
    path_type_s  = 2'b00;
    case (state_s)
      FETCH_0: mar_load_s = 1'b1;
      FETCH_1: pc_inc_s   = 1'b1;
      FETCH_2: ir_load_s  = 1'b1;
      EXEC: begin
        reg_we_s     = 1'b1;
        adr_3_s      = fa_s;
        write_data_s = fb_s;
        path_type_s  = 2'b10;
      end
      MEM_RD: begin
        rd_en_s = 1'b1;
        adr_3_s = fa_s;
        adr_1_s = fb_s;
      end
      MEM_WB: begin
        reg_we_s    = 1'b1;
        adr_3_s     = fa_s;
        path_type_s = 2'b01;
      end
      MEM_WR: begin
        reg_re_s = 1'b1;
        wr_en_s  = 1'b1;
        adr_1_s  = fa_s;
        adr_2_s  = fb_s;
      end
      ALU_0: begin
        reg_re_s  = 1'b1;
        alu_sel_s = op_s;
        adr_1_s   = is_mov_s ? fb_s : fa_s;
        adr_2_s   = is_mov_s ? '0 : fb_s;
      end
      ALU_1:   alu_sel_s = op_s;
      ALU_2: begin
        reg_we_s  = 1'b1;
        alu_sel_s = op_s;
        adr_3_s   = fa_s;
      end
      JUMP: begin
        pc_en_s   = 1'b1;
        pc_load_s = jump_tgt_s;
      end
      FAULT:   fault_s = 1'b1;
      default: fault_s = 1'b0;
    endcase
  end

  // State, instruction latch, stack pointer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= FETCH_0;
      ir_r           <= '0;
      sp_r           <= '0;
      count_r        <= '0;
      PC_load        <= '0;
      write_data     <= '0;
      ALU_sel        <= '0;
      ADR_1          <= '0;
      ADR_2          <= '0;
      ADR_3          <= '0;
      PC_en          <= 1'b0;
      PC_inc         <= 1'b0;
      MAR_load       <= 1'b0;
      IR_load        <= 1'b0;
      regWriteEnable <= 1'b0;
      regReadEnable  <= 1'b0;
      rd_en          <= 1'b0;
      wr_en          <= 1'b0;
      fault          <= 1'b0;
      Path_Type      <= 2'b00;
    end else begin
      state_r        <= state_s;
      ir_r           <= instr_s;
      PC_load        <= pc_load_s;
      write_data     <= write_data_s;
      ALU_sel        <= alu_sel_s;
      ADR_1          <= adr_1_s;
      ADR_2          <= adr_2_s;
      ADR_3          <= adr_3_s;
      PC_en          <= pc_en_s;
      PC_inc         <= pc_inc_s;
      MAR_load       <= mar_load_s;
      IR_load        <= ir_load_s;
      regWriteEnable <= reg_we_s;
      regReadEnable  <= reg_re_s;
      rd_en          <= rd_en_s;
      wr_en          <= wr_en_s;
      fault          <= fault_s;
      Path_Type      <= path_type_s;
      if (push_s) begin
        sp_r    <= sp_r + SP_W'(1);
        count_r <= count_r + (SP_W+1)'(1);
      end else if (pop_s) begin
        sp_r    <= sp_dec_s;
        count_r <= count_r - (SP_W+1)'(1);
      end else begin
        sp_r    <= sp_r;
        count_r <= count_r;
      end
    end
  end

  // Return-stack storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_mem[sp_r] <= PC_current_value;
    end
  end

  assign current_state_out = state_r;
  assign stack_count       = count_r;

endmodule

// File: tb/tb_control_unit_param.sv
// Self-checking bench: an instruction-level model predicts every cycle's outputs,
// plus literal spot checks on the main scenarios.
module tb_control_unit_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] command_word = 24'h0;
  logic        ReadyRegFlag = 1'b0;
  logic [7:0]  PC_current_value = 8'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [7:0]  PC_load, write_data, ALU_sel, ADR_1, ADR_2, ADR_3;
  logic        PC_en, PC_inc, MAR_load, IR_load, regWriteEnable, regReadEnable;
  logic        rd_en, wr_en, fault;
  logic [1:0]  Path_Type;
  logic [4:0]  current_state_out;
  logic [4:0]  stack_count;

  control_unit_param #(.FIELD_W(8), .STACK_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .command_word(command_word), .ReadyRegFlag(ReadyRegFlag),
    .PC_current_value(PC_current_value), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .PC_load(PC_load), .PC_en(PC_en), .PC_inc(PC_inc), .MAR_load(MAR_load),
    .IR_load(IR_load), .write_data(write_data), .ALU_sel(ALU_sel), .ADR_1(ADR_1),
    .ADR_2(ADR_2), .ADR_3(ADR_3), .regWriteEnable(regWriteEnable),
    .regReadEnable(regReadEnable), .Path_Type(Path_Type), .rd_en(rd_en), .wr_en(wr_en),
    .current_state_out(current_state_out), .fault(fault), .stack_count(stack_count)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] S_F0 = 5'd0, S_F1 = 5'd1, S_F2 = 5'd2, S_DEC = 5'd3,
                         S_EXE = 5'd4, S_MRD = 5'd5, S_MWB = 5'd6, S_MWR = 5'd7,
                         S_A0 = 5'd8, S_A1 = 5'd9, S_A2 = 5'd10, S_JMP = 5'd11,
                         S_FLT = 5'd31;

  typedef struct packed {
    logic [4:0] st;
    logic       mar, inc, irl, pcen;
    logic [7:0] pcl, wd, sel, a1, a2, a3;
    logic       rwe, rre;
    logic [1:0] pt;
    logic       rd, wr, flt;
    logic [4:0] cnt;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;

  obs_t       exp_q[$];
  lit_t       lit_q[$];
  logic [7:0] model_stack[$];
  bit         model_fault = 1'b0;
  bit         after_reset = 1'b0;
  int         n_cmp = 0, n_bad = 0;
  int         pc_en_cnt = 0, rd_cnt = 0;
  logic [7:0] last_pcl = 8'h0, last_a3 = 8'h0, last_wd = 8'h0;
  logic [1:0] last_pt = 2'b00;
  int         b_pc, b_rd;

  // Single compare process: per-cycle model check plus queued literal checks.
  always @(negedge clk) begin
    obs_t e, act;
    lit_t l;
    act = {current_state_out, MAR_load, PC_inc, IR_load, PC_en, PC_load, write_data,
           ALU_sel, ADR_1, ADR_2, ADR_3, regWriteEnable, regReadEnable, Path_Type,
           rd_en, wr_en, fault, stack_count};
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
      end
      if (PC_en) begin
        pc_en_cnt++;
        last_pcl = PC_load;
      end
      if (regWriteEnable) begin
        last_a3 = ADR_3;
        last_wd = write_data;
        last_pt = Path_Type;
      end
      if (rd_en) rd_cnt++;
    end
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      n_cmp++;
      if (l.act !== l.exp) begin
        n_bad++;
        $display("FAIL %s actual=%h required=%h", l.name, l.act, l.exp);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] a, input logic [31:0] e);
    lit_t t;
    t.name = name;
    t.act  = a;
    t.exp  = e;
    lit_q.push_back(t);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t blank(input logic [4:0] st);
    obs_t o;
    o     = '0;
    o.st  = st;
    o.cnt = 5'(model_stack.size());
    return o;
  endfunction

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    lit({tag, "_state"}, 32'(current_state_out), 32'd0);
    lit({tag, "_strobes"}, 32'({MAR_load, PC_inc, IR_load, PC_en, regWriteEnable,
        regReadEnable, rd_en, wr_en}), 32'd0);
    lit({tag, "_fault"}, 32'(fault), 32'd0);
    lit({tag, "_count"}, 32'(stack_count), 32'd0);
    lit({tag, "_buses"}, 32'(PC_load | write_data | ALU_sel | ADR_1 | ADR_2 | ADR_3 |
        {6'd0, Path_Type}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_stack.delete();
    model_fault = 1'b0;
    after_reset = 1'b1;
  endtask

  task automatic push_jump(input logic [7:0] tgt);
    obs_t e;
    e = blank(S_JMP); e.pcen = 1'b1; e.pcl = tgt;
    exp_q.push_back(e); cycle();
  endtask

  task automatic enter_fault();
    obs_t e;
    model_fault = 1'b1;
    e = blank(S_FLT); e.flt = 1'b1;
    exp_q.push_back(e); cycle();
  endtask

  // Instruction-level model: emits one expected observation per cycle.
  task automatic run_instr(input logic [7:0] op, input logic [7:0] fa, input logic [7:0] fb,
                           input bit ready, input bit az, input logic [7:0] pcv,
                           input int mem_wait, input int abort_after);
    obs_t e;
    logic [7:0] t;
    command_word = {op, fa, fb};
    ReadyRegFlag = ready;
    alu_zero = az;
    PC_current_value = pcv;
    mem_ready = 1'b0;
    if (model_fault) begin
      repeat (4) begin
        e = blank(S_FLT); e.flt = 1'b1;
        exp_q.push_back(e); cycle();
      end
      return;
    end
    e = blank(S_F0); e.mar = !after_reset; after_reset = 1'b0;
    exp_q.push_back(e); cycle();
    e = blank(S_F1); e.inc = 1'b1; exp_q.push_back(e); cycle();
    e = blank(S_F2); e.irl = 1'b1; exp_q.push_back(e); cycle();
    if (!ready) return;
    e = blank(S_DEC); exp_q.push_back(e); cycle();
    if (op == 8'h00) begin
      return;
    end else if (op == 8'h01) begin
      e = blank(S_EXE); e.rwe = 1'b1; e.a3 = fa; e.wd = fb; e.pt = 2'b10;
      exp_q.push_back(e); cycle();
    end else if (op == 8'h02 || op == 8'h03) begin
      for (int i = 0; i <= mem_wait; i++) begin
        if (abort_after >= 0 && i == abort_after) return;
        mem_ready = (i == mem_wait);
        if (op == 8'h02) begin
          e = blank(S_MRD); e.rd = 1'b1; e.a3 = fa; e.a1 = fb;
        end else begin
          e = blank(S_MWR); e.wr = 1'b1; e.rre = 1'b1; e.a1 = fa; e.a2 = fb;
        end
        exp_q.push_back(e); cycle();
      end
      mem_ready = 1'b0;
      if (op == 8'h02) begin
        e = blank(S_MWB); e.rwe = 1'b1; e.a3 = fa; e.pt = 2'b01;
        exp_q.push_back(e); cycle();
      end
    end else if (op == 8'h04) begin
      e = blank(S_A0); e.rre = 1'b1; e.a1 = fb; e.sel = op; exp_q.push_back(e); cycle();
      e = blank(S_A2); e.rwe = 1'b1; e.a3 = fa; e.sel = op; exp_q.push_back(e); cycle();
    end else if (op >= 8'h10 && op <= 8'h2F) begin
      e = blank(S_A0); e.rre = 1'b1; e.a1 = fa; e.a2 = fb; e.sel = op;
      exp_q.push_back(e); cycle();
      e = blank(S_A1); e.sel = op; exp_q.push_back(e); cycle();
      e = blank(S_A2); e.rwe = 1'b1; e.a3 = fa; e.sel = op; exp_q.push_back(e); cycle();
    end else if (op == 8'h30) begin
      push_jump(fa);
    end else if (op == 8'h31) begin
      if (az) push_jump(fa);
    end else if (op == 8'h32) begin
      if (!az) push_jump(fa);
    end else if (op == 8'h33) begin
      if (model_stack.size() == 16) begin
        enter_fault();
      end else begin
        model_stack.push_back(pcv);
        push_jump(fa);
      end
    end else if (op == 8'h34) begin
      if (model_stack.size() == 0) begin
        enter_fault();
      end else begin
        t = model_stack.pop_back();
        push_jump(t);
      end
    end else begin
      enter_fault();
    end
  endtask

  initial begin
    #1;
    do_reset("reset");

    run_instr(8'h01, 8'h05, 8'h2A, 1'b1, 1'b0, 8'h01, 0, -1);
    lit("str_imm_adr3", 32'(last_a3), 32'h05);
    lit("str_imm_wdata", 32'(last_wd), 32'h2A);
    lit("str_imm_path", 32'(last_pt), 32'h2);

    run_instr(8'h10, 8'h03, 8'h04, 1'b1, 1'b0, 8'h02, 0, -1);
    lit("alu_adr3", 32'(last_a3), 32'h03);
    lit("alu_path", 32'(last_pt), 32'h0);

    b_rd = rd_cnt;
    run_instr(8'h02, 8'h01, 8'h80, 1'b1, 1'b0, 8'h03, 3, -1);
    lit("loa_rd_cycles", 32'(rd_cnt - b_rd), 32'd4);
    lit("loa_path", 32'(last_pt), 32'h1);

    b_pc = pc_en_cnt;
    run_instr(8'h31, 8'h40, 8'h00, 1'b1, 1'b1, 8'h04, 0, -1);
    lit("jz_taken_count", 32'(pc_en_cnt - b_pc), 32'd1);
    lit("jz_taken_target", 32'(last_pcl), 32'h40);
    b_pc = pc_en_cnt;
    run_instr(8'h31, 8'h40, 8'h00, 1'b1, 1'b0, 8'h05, 0, -1);
    lit("jz_not_taken", 32'(pc_en_cnt - b_pc), 32'd0);
    run_instr(8'h32, 8'h55, 8'h00, 1'b1, 1'b0, 8'h06, 0, -1);
    lit("jnz_target", 32'(last_pcl), 32'h55);

    run_instr(8'h03, 8'h02, 8'h90, 1'b1, 1'b0, 8'h07, 1, -1);
    run_instr(8'h04, 8'h07, 8'h03, 1'b1, 1'b0, 8'h08, 0, -1);
    run_instr(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h09, 0, -1);
    run_instr(8'h01, 8'h06, 8'h11, 1'b0, 1'b0, 8'h0A, 0, -1);
    run_instr(8'h30, 8'h77, 8'h00, 1'b1, 1'b0, 8'h0B, 0, -1);

    run_instr(8'h33, 8'h20, 8'h00, 1'b1, 1'b0, 8'h07, 0, -1);
    lit("call_target", 32'(last_pcl), 32'h20);
    lit("call_count", 32'(stack_count), 32'd1);
    run_instr(8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 8'h21, 0, -1);
    lit("ret_target", 32'(last_pcl), 32'h07);
    lit("ret_count", 32'(stack_count), 32'd0);

    for (int i = 0; i < 17; i++) begin
      run_instr(8'h33, 8'(8'h60 + i), 8'h00, 1'b1, 1'b0, 8'(i), 0, -1);
      if (i == 15) lit("call_depth_16", 32'(stack_count), 32'd16);
    end
    lit("overflow_fault", 32'(fault), 32'd1);
    run_instr(8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 8'h00, 0, -1);
    lit("fault_sticky", 32'(fault), 32'd1);
    lit("fault_state", 32'(current_state_out), 32'd31);

    do_reset("reset_after_overflow");
    run_instr(8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 0, -1);
    lit("underflow_fault", 32'(fault), 32'd1);

    do_reset("reset_after_underflow");
    run_instr(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 0, -1);
    lit("illegal_fault", 32'(fault), 32'd1);

    do_reset("reset_after_illegal");
    run_instr(8'h33, 8'h30, 8'h00, 1'b1, 1'b0, 8'h09, 0, -1);
    run_instr(8'h02, 8'h04, 8'h81, 1'b1, 1'b0, 8'h31, 10, 2);
    lit("abort_pre_state", 32'(current_state_out), 32'd5);
    lit("abort_pre_count", 32'(stack_count), 32'd1);
    do_reset("reset_mid_wait");
    run_instr(8'h01, 8'h0C, 8'h3C, 1'b1, 1'b0, 8'h01, 0, -1);
    lit("resume_wdata", 32'(last_wd), 32'h3C);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
